// File: rtl/countdown_display_ctrl_pkg.sv
// Shared types and helpers for the MM:SS countdown display controller.
// Provides the controller state enum, the blank-digit code, the 2-digit BCD
// payload, the four-digit display payload and the digit mapping function.
package game_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] u;
  } bcd2_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } disp4_t;

  // Binary 0..99 to two BCD digits (used for parameter-time reload values).
  function automatic bcd2_t to_bcd2(input int unsigned v);
    bcd2_t r;
    r.t = 4'(v / 32'd10);
    r.u = 4'(v % 32'd10);
    return r;
  endfunction

  // Live counter to displayed digits: leading minute-tens zero is blanked,
  // blank_all forces every digit dark (blink off phase).
  function automatic disp4_t map_display(input bcd2_t m, input bcd2_t s,
                                         input logic blank_all);
    disp4_t d;
    if (blank_all) begin
      d = {4{DIGIT_BLANK}};
    end else begin
      d.mt = (m.t == 4'd0) ? DIGIT_BLANK : m.t;
      d.mu = m.u;
      d.st = s.t;
      d.su = s.u;
    end
    return d;
  endfunction

endpackage

// File: rtl/countdown_display_ctrl_if.sv
// Control/display bundle between the game logic and the countdown controller.
// master: drives start/pause/load/frame_start, observes digits and status.
// slave : the controller side.
interface countdown_display_ctrl_if;
  logic       start;
  logic       pause;
  logic       load;
  logic       frame_start;
  logic [3:0] dig_mt;
  logic [3:0] dig_mu;
  logic [3:0] dig_st;
  logic [3:0] dig_su;
  logic       running;
  logic       expired;

  modport master (
    output start, pause, load, frame_start,
    input  dig_mt, dig_mu, dig_st, dig_su, running, expired
  );

  modport slave (
    input  start, pause, load, frame_start,
    output dig_mt, dig_mu, dig_st, dig_su, running, expired
  );
endinterface

// File: rtl/countdown_display_ctrl_bcd2_down.sv
// Two-digit BCD down-counter step (combinational).
// val_i    : current value
// dec_o    : value minus one, units wrap 0->9, tens wrap 0->TENS_MAX
// borrow_o : set when the value wrapped below 00
// zero_o   : current value is 00
module bcd2_down
  import game_pkg::*;
#(
  parameter int unsigned TENS_MAX = 5
) (
  input  bcd2_t val_i,
  output bcd2_t dec_o,
  output logic  borrow_o,
  output logic  zero_o
);

  always_comb begin
    dec_o    = val_i;
    borrow_o = 1'b0;
    if (val_i.u == 4'd0) begin
      dec_o.u = 4'd9;
      if (val_i.t == 4'd0) begin
        dec_o.t  = 4'(TENS_MAX);
        borrow_o = 1'b1;
      end else begin
        dec_o.t = val_i.t - 4'd1;
      end
    end else begin
      dec_o.u = val_i.u - 4'd1;
    end
  end

  assign zero_o = (val_i == '0);

endmodule

// File: rtl/countdown_display_ctrl.sv
// MM:SS countdown controller with frame-synchronous digit latching.
// clk, rst : clock and synchronous active-high reset
// bus      : start/pause/load/frame_start in; four digit codes,
//            running and the one-cycle expired pulse out (all registered)
module countdown_display_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned INIT_MIN  = 2,
  parameter int unsigned INIT_SEC  = 0,
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input logic                     clk,
  input logic                     rst,
  countdown_display_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam bcd2_t  INIT_M    = to_bcd2(INIT_MIN);
  localparam bcd2_t  INIT_S    = to_bcd2(INIT_SEC);
  localparam disp4_t DISP_INIT = map_display(INIT_M, INIT_S, 1'b0);

  cd_state_t   state_q, state_d;
  bcd2_t       min_q, min_d, sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;
  logic        running_q, running_d;
  logic        expired_q, expired_d;
  disp4_t      disp_q, disp_d;

  bcd2_t sec_dec, min_dec;
  logic  sec_borrow, min_borrow, sec_zero, min_zero;
  logic  tick_c, cnt_zero_c;
  disp4_t disp_c;

  bcd2_down #(.TENS_MAX(5)) u_sec (
    .val_i(sec_q), .dec_o(sec_dec), .borrow_o(sec_borrow), .zero_o(sec_zero)
  );

  bcd2_down #(.TENS_MAX(5)) u_min (
    .val_i(min_q), .dec_o(min_dec), .borrow_o(min_borrow), .zero_o(min_zero)
  );

  assign tick_c     = (presc_q == PW'(TICK_DIV - 1));
  assign cnt_zero_c = min_zero & sec_zero;

  // Next-state, counter, prescaler, blink and display-latch logic.
  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    sec_d       = sec_q;
    presc_d     = presc_q;
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    expired_d   = 1'b0;
    disp_c      = map_display(min_q, sec_q, (state_q == DONE) && !blink_on_q);
    disp_d      = bus.frame_start ? disp_c : disp_q;

    if (bus.load) begin
      state_d = IDLE;
      min_d   = INIT_M;
      sec_d   = INIT_S;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          if (bus.start && !bus.pause) begin
            if (cnt_zero_c) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else if (tick_c) begin
            presc_d = '0;
            if (!cnt_zero_c) begin
              sec_d = sec_dec;
              // Minutes only borrow from seconds and never wrap below 00.
              if (sec_borrow && !min_borrow) min_d = min_dec;
              if (min_zero && (sec_dec == '0)) begin
                state_d   = DONE;
                expired_d = 1'b1;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (bus.start && !bus.pause) state_d = RUN;
        end
        DONE: begin
          presc_d = '0;
          if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = !blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            blink_on_d  = blink_on_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      min_q       <= INIT_M;
      sec_q       <= INIT_S;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
      disp_q      <= DISP_INIT;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      running_q   <= running_d;
      expired_q   <= expired_d;
      disp_q      <= disp_d;
    end
  end

  assign bus.dig_mt  = disp_q.mt;
  assign bus.dig_mu  = disp_q.mu;
  assign bus.dig_st  = disp_q.st;
  assign bus.dig_su  = disp_q.su;
  assign bus.running = running_q;
  assign bus.expired = expired_q;

endmodule
